cdb_arb: RTL and testbench

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/sys_defs.sv | 24 ++
 rtl/cdb_fifo.sv | 123 ++++++++++++
 rtl/cdb_arb.sv | 103 ++++++++++
 tb/tb_cdb_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared widths, result source ids and the CDB packet type
package sys_defs;

    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 5;
    localparam int BR_MASK_W = 4;
    localparam int N_SRC_DEF = 3;

    localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MULT = 2'd1,
        SRC_LD   = 2'd2
    } src_id_e;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] tag;
        logic [63:0]          value;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-source result buffer with branch squash/compaction and mask fix
module cdb_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  cdb_pkt_t             push_pkt_i,
    input  logic                 pop_i,
    input  logic                 br_recovery_i,
    input  logic                 br_pred_correct_i,
    input  logic [BR_MASK_W-1:0] br_tag_fix_i,
    output logic                 rdy_o,
    output logic                 head_vld_o,
    output cdb_pkt_t             head_pkt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_pkt_t         mem_q [DEPTH];
    cdb_pkt_t         mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Logical view: stored entries oldest first, then the incoming push.
    cdb_pkt_t         ent [DEPTH+1];
    logic [DEPTH:0]   ent_v;
    logic [DEPTH:0]   ent_live;
    int               head_pos;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign rdy_o = (cnt_q < CNT_W'(DEPTH));

    always_comb begin
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < int'(cnt_q)) begin
                ent[i]   = mem_q[PTR_W'((int'(rd_ptr_q) + i) % DEPTH)];
                ent_v[i] = 1'b1;
            end else begin
                ent[i]   = push_pkt_i;
                ent_v[i] = (i == int'(cnt_q)) && push_i;
            end
            ent_live[i] = ent_v[i] && !(br_recovery_i && |(ent[i].br_mask & br_tag_fix_i));
        end
    end

    // Head is the oldest survivor; an empty buffer offers the incoming push directly.
    always_comb begin
        head_pos   = 0;
        head_vld_o = 1'b0;
        for (int i = DEPTH; i >= 0; i--) begin
            if (ent_live[i]) begin
                head_pos   = i;
                head_vld_o = 1'b1;
            end
        end
        head_pkt_o = ent[head_pos];
        if (br_pred_correct_i) begin
            head_pkt_o.br_mask = head_pkt_o.br_mask & ~br_tag_fix_i;
        end
    end

    always_comb begin
        logic push_st;
        logic pop_st;
        int   n;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        push_st  = 1'b0;
        pop_st   = 1'b0;
        n        = 0;
        if (br_recovery_i) begin
            for (int i = 0; i <= DEPTH; i++) begin
                if (ent_live[i] && !(pop_i && i == head_pos)) begin
                    mem_d[PTR_W'(n)] = ent[i];
                    n = n + 1;
                end
            end
            rd_ptr_d = '0;
            wr_ptr_d = PTR_W'(n % DEPTH);
            cnt_d    = CNT_W'(n);
        end else begin
            push_st = push_i && !(pop_i && cnt_q == '0);
            pop_st  = pop_i && cnt_q != '0;
            if (push_st) begin
                mem_d[wr_ptr_q] = push_pkt_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_st) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(push_st) - CNT_W'(pop_st);
        end
        if (br_pred_correct_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_d[j].br_mask = mem_d[j].br_mask & ~br_tag_fix_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_arb.sv
// rtl/cdb_arb.sv - round-robin arbitration of result sources onto the single common data bus
module cdb_arb
    import sys_defs::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_SRC-1:0]                  src_vld_i,
    input  logic [N_SRC-1:0][PRF_IDX_W-1:0]   src_tag_i,
    input  logic [N_SRC-1:0][63:0]            src_value_i,
    input  logic [N_SRC-1:0][ROB_IDX_W-1:0]   src_rob_idx_i,
    input  logic [N_SRC-1:0][BR_MASK_W-1:0]   src_br_mask_i,
    output logic [N_SRC-1:0]                  src_rdy_o,
    input  logic                              rob_br_recovery_i,
    input  logic                              rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i,
    output logic                              cdb_vld_o,
    output logic [PRF_IDX_W-1:0]              cdb_tag_o,
    output logic [63:0]                       cdb_value_o,
    output logic [ROB_IDX_W-1:0]              cdb_rob_idx_o
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] head_vld;
    logic [N_SRC-1:0] pop;
    cdb_pkt_t         head_pkt [N_SRC];

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_vld;
    logic             cdb_vld_q, cdb_vld_d;
    cdb_pkt_t         cdb_pkt_q, cdb_pkt_d;
    logic             out_squash;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        cdb_pkt_t in_pkt;
        assign in_pkt = '{tag:     src_tag_i[k],
                          value:   src_value_i[k],
                          rob_idx: src_rob_idx_i[k],
                          br_mask: src_br_mask_i[k]};

        cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk               (clk),
            .rst               (rst),
            .push_i            (src_vld_i[k] & src_rdy_o[k]),
            .push_pkt_i        (in_pkt),
            .pop_i             (pop[k]),
            .br_recovery_i     (rob_br_recovery_i),
            .br_pred_correct_i (rob_br_pred_correct_i),
            .br_tag_fix_i      (rob_br_tag_fix_i),
            .rdy_o             (src_rdy_o[k]),
            .head_vld_o        (head_vld[k]),
            .head_pkt_o        (head_pkt[k])
        );
    end

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_SRC;
            if (!grant_vld && head_vld[SRC_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + SRC_W'(1);
        end
        cdb_vld_d = grant_vld;
        cdb_pkt_d = grant_vld ? head_pkt[grant_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            cdb_vld_q <= 1'b0;
            cdb_pkt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_pkt_q <= cdb_pkt_d;
        end
    end

    // A recovery arriving while a result sits in the output register kills it on the spot.
    assign out_squash    = rob_br_recovery_i && |(cdb_pkt_q.br_mask & rob_br_tag_fix_i);
    assign cdb_vld_o     = cdb_vld_q && !out_squash;
    assign cdb_tag_o     = cdb_vld_o ? cdb_pkt_q.tag : ZERO_REG;
    assign cdb_value_o   = cdb_vld_o ? cdb_pkt_q.value : '0;
    assign cdb_rob_idx_o = cdb_vld_o ? cdb_pkt_q.rob_idx : '0;

endmodule

// File: tb/tb_cdb_arb.sv
// tb/tb_cdb_arb.sv - directed self-checking bench for cdb_arb
module tb_cdb_arb;
    import sys_defs::*;

    localparam int N = 3;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [N-1:0]                    src_vld_i;
    logic [N-1:0][PRF_IDX_W-1:0]     src_tag_i;
    logic [N-1:0][63:0]              src_value_i;
    logic [N-1:0][ROB_IDX_W-1:0]     src_rob_idx_i;
    logic [N-1:0][BR_MASK_W-1:0]     src_br_mask_i;
    logic [N-1:0]                    src_rdy_o;
    logic                            rob_br_recovery_i;
    logic                            rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0]            rob_br_tag_fix_i;
    logic                            cdb_vld_o;
    logic [PRF_IDX_W-1:0]            cdb_tag_o;
    logic [63:0]                     cdb_value_o;
    logic [ROB_IDX_W-1:0]            cdb_rob_idx_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdb_arb #(.N_SRC(N), .DEPTH(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .src_vld_i             (src_vld_i),
        .src_tag_i             (src_tag_i),
        .src_value_i           (src_value_i),
        .src_rob_idx_i         (src_rob_idx_i),
        .src_br_mask_i         (src_br_mask_i),
        .src_rdy_o             (src_rdy_o),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .cdb_vld_o             (cdb_vld_o),
        .cdb_tag_o             (cdb_tag_o),
        .cdb_value_o           (cdb_value_o),
        .cdb_rob_idx_o         (cdb_rob_idx_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [PRF_IDX_W-1:0] t,
                           input logic [63:0] v);
        logic [ROB_IDX_W-1:0] rob;
        rob = vld ? t[ROB_IDX_W-1:0] : '0;
        chk({tag, ".vld"}, 64'(cdb_vld_o), 64'(vld));
        chk({tag, ".tag"}, 64'(cdb_tag_o), 64'(vld ? t : ZERO_REG));
        chk({tag, ".val"}, cdb_value_o, vld ? v : 64'd0);
        chk({tag, ".rob"}, 64'(cdb_rob_idx_o), 64'(rob));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        src_vld_i             = '0;
        src_tag_i             = '0;
        src_value_i           = '0;
        src_rob_idx_i         = '0;
        src_br_mask_i         = '0;
        rob_br_recovery_i     = 1'b0;
        rob_br_pred_correct_i = 1'b0;
        rob_br_tag_fix_i      = '0;
    endtask

    // The ROB index driven is always the low bits of the tag, so expectations stay compact.
    task automatic drive(input src_id_e k, input logic [PRF_IDX_W-1:0] t, input logic [63:0] v,
                         input logic [BR_MASK_W-1:0] m);
        src_vld_i[k]     = 1'b1;
        src_tag_i[k]     = t;
        src_value_i[k]   = v;
        src_rob_idx_i[k] = t[ROB_IDX_W-1:0];
        src_br_mask_i[k] = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clr_in();
        do_reset();
        chk_out("reset", 1'b0, 6'd0, 64'd0);
        chk("reset_rdy", 64'(src_rdy_o), 64'h7);

        // Single ALU result: one-cycle latency, then idle.
        drive(SRC_ALU, 6'd5, 64'hAA, 4'b0000);
        tick(); clr_in();
        chk_out("alu_c1", 1'b1, 6'd5, 64'hAA);
        tick();
        chk_out("alu_c2", 1'b0, 6'd0, 64'd0);

        // All three at once from rr_ptr=0, then probe rr_ptr with ALU+MULT.
        do_reset();
        drive(SRC_ALU, 6'd10, 64'd100, 4'b0000);
        drive(SRC_MULT, 6'd11, 64'd101, 4'b0000);
        drive(SRC_LD, 6'd12, 64'd102, 4'b0000);
        tick(); clr_in();
        chk_out("all3_alu", 1'b1, 6'd10, 64'd100);
        tick();
        chk_out("all3_mult", 1'b1, 6'd11, 64'd101);
        tick();
        chk_out("all3_ld", 1'b1, 6'd12, 64'd102);
        tick();
        chk_out("all3_idle", 1'b0, 6'd0, 64'd0);
        drive(SRC_MULT, 6'd13, 64'd103, 4'b0000);
        drive(SRC_ALU, 6'd14, 64'd104, 4'b0000);
        tick(); clr_in();
        chk_out("rr0_alu", 1'b1, 6'd14, 64'd104);
        tick();
        chk_out("rr0_mult", 1'b1, 6'd13, 64'd103);
        tick();
        chk_out("rr0_idle", 1'b0, 6'd0, 64'd0);

        // MULT fills while losing; a push offered while full is refused.
        do_reset();
        drive(SRC_MULT, 6'd20, 64'd200, 4'b0000);
        tick(); clr_in();
        chk_out("full_m20", 1'b1, 6'd20, 64'd200);
        drive(SRC_LD, 6'd30, 64'd300, 4'b0000);
        drive(SRC_MULT, 6'd21, 64'd201, 4'b0000);
        tick(); clr_in();
        chk_out("full_ld30", 1'b1, 6'd30, 64'd300);
        drive(SRC_ALU, 6'd40, 64'd400, 4'b0000);
        drive(SRC_MULT, 6'd22, 64'd202, 4'b0000);
        tick(); clr_in();
        chk_out("full_alu40", 1'b1, 6'd40, 64'd400);
        chk("full_rdy_lo", 64'(src_rdy_o[SRC_MULT]), 64'd0);
        drive(SRC_MULT, 6'd39, 64'd999, 4'b0000);
        #1;
        chk("full_rdy_pop_cycle", 64'(src_rdy_o[SRC_MULT]), 64'd0);
        tick(); clr_in();
        chk_out("full_m21", 1'b1, 6'd21, 64'd201);
        chk("full_rdy_hi", 64'(src_rdy_o[SRC_MULT]), 64'd1);
        tick();
        chk_out("full_m22", 1'b1, 6'd22, 64'd202);
        tick();
        chk_out("full_idle", 1'b0, 6'd0, 64'd0);

        // LD holds masks 0010 and 0100; recovery on 0010 leaves only the second.
        do_reset();
        drive(SRC_ALU, 6'd1, 64'd1, 4'b0000);
        drive(SRC_LD, 6'd50, 64'd500, 4'b0010);
        tick(); clr_in();
        chk_out("sq_alu", 1'b1, 6'd1, 64'd1);
        drive(SRC_LD, 6'd51, 64'd501, 4'b0100);
        drive(SRC_MULT, 6'd2, 64'd2, 4'b0000);
        tick(); clr_in();
        chk_out("sq_mult", 1'b1, 6'd2, 64'd2);
        chk("sq_ld_rdy_lo", 64'(src_rdy_o[SRC_LD]), 64'd0);
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0010;
        #1;
        chk_out("sq_out_survives", 1'b1, 6'd2, 64'd2);
        tick(); clr_in();
        chk_out("sq_ld51", 1'b1, 6'd51, 64'd501);
        chk("sq_ld_rdy_hi", 64'(src_rdy_o[SRC_LD]), 64'd1);
        tick();
        chk_out("sq_idle1", 1'b0, 6'd0, 64'd0);
        tick();
        chk_out("sq_idle2", 1'b0, 6'd0, 64'd0);

        // Recovery hitting the output register in the same cycle.
        do_reset();
        drive(SRC_ALU, 6'd7, 64'd7, 4'b0001);
        tick(); clr_in();
        chk_out("oreg_vld", 1'b1, 6'd7, 64'd7);
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0001;
        #1;
        chk_out("oreg_squash", 1'b0, 6'd0, 64'd0);
        tick(); clr_in();
        chk_out("oreg_after", 1'b0, 6'd0, 64'd0);

        // pred_correct clears bit 1 of a stored 0011 mask; recovery on 0010 must spare it.
        do_reset();
        drive(SRC_ALU, 6'd60, 64'd600, 4'b0000);
        drive(SRC_LD, 6'd61, 64'd601, 4'b0011);
        tick(); clr_in();
        chk_out("fix_alu", 1'b1, 6'd60, 64'd600);
        rob_br_pred_correct_i = 1'b1;
        rob_br_tag_fix_i      = 4'b0010;
        drive(SRC_MULT, 6'd62, 64'd620, 4'b0000);
        tick(); clr_in();
        chk_out("fix_mult", 1'b1, 6'd62, 64'd620);
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0010;
        #1;
        chk_out("fix_rec_out", 1'b1, 6'd62, 64'd620);
        tick(); clr_in();
        chk_out("fix_ld61", 1'b1, 6'd61, 64'd601);
        rob_br_recovery_i = 1'b1;
        rob_br_tag_fix_i  = 4'b0010;
        #1;
        chk("fix_mask_bit1_clear", 64'(cdb_vld_o), 64'd1);
        rob_br_tag_fix_i  = 4'b0001;
        #1;
        chk("fix_mask_bit0_kept", 64'(cdb_vld_o), 64'd0);
        clr_in();
        tick();
        chk_out("fix_idle", 1'b0, 6'd0, 64'd0);

        // Reset mid-operation discards buffered results.
        do_reset();
        drive(SRC_ALU, 6'd20, 64'd700, 4'b0000);
        drive(SRC_MULT, 6'd21, 64'd701, 4'b0000);
        drive(SRC_LD, 6'd22, 64'd702, 4'b0000);
        tick(); clr_in();
        chk_out("mid_alu", 1'b1, 6'd20, 64'd700);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 1'b0, 6'd0, 64'd0);
        chk("mid_rst_rdy", 64'(src_rdy_o), 64'h7);
        rst = 1'b0;
        tick();
        chk_out("mid_post1", 1'b0, 6'd0, 64'd0);
        tick();
        chk_out("mid_post2", 1'b0, 6'd0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
